// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush and data-memory freeze sequencer for the 5-stage RV32I core.
// Optional `HAZARD_STATS_EN adds o_stall_cycles / o_flush_count event counters.
`timescale 1ns/1ps
module hazard_controller #(
  parameter int MEM_TIMEOUT = 256,
  parameter int TO_W        = 9
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_ID_rs1_addr,
  input  logic [4:0] i_ID_rs2_addr,
  input  logic       i_ID_rs1_used,
  input  logic       i_ID_rs2_used,
  input  logic [4:0] i_EX_rd_addr,
  input  logic       i_EX_load,
  input  logic       i_EX_br_taken,
  input  logic       i_MEM_mem_req,
  input  logic       i_dmem_ack,
  output logic       o_dmem_req,
  output logic       o_pc_en,
  output logic       o_IF_ID_en,
  output logic       o_IF_ID_flush,
  output logic       o_ID_EX_en,
  output logic       o_ID_EX_flush,
  output logic       o_EX_MEM_en,
  output logic       o_MEM_WB_en,
  output logic       o_mem_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count
`endif
);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [TO_W-1:0] CNT_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0] CNT_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] CNT_LAST  = TO_W'(MEM_TIMEOUT - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [TO_W-1:0]   wait_cnt_r;
  logic              timeout_r;
  logic              wait_s;
  logic              lu_s;
  logic              rs1_hit_s;
  logic              rs2_hit_s;

  // A pending access blocks every stage until the memory acknowledges it.
  assign wait_s = ((state_r == S_RUN) & i_MEM_mem_req & ~i_dmem_ack) |
                  ((state_r == S_MEM_WAIT) & ~i_dmem_ack);

  assign rs1_hit_s = i_ID_rs1_used & (i_ID_rs1_addr == i_EX_rd_addr);
  assign rs2_hit_s = i_ID_rs2_used & (i_ID_rs2_addr == i_EX_rd_addr);
  assign lu_s      = i_EX_load & (i_EX_rd_addr != 5'd0) & (rs1_hit_s | rs2_hit_s);

  assign o_mem_timeout = timeout_r;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= S_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: an ack in the request cycle never enters the wait state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_RUN: begin
        if (wait_s) state_nxt_s = S_MEM_WAIT;
        else        state_nxt_s = S_RUN;
      end
      S_MEM_WAIT: begin
        if (i_dmem_ack) state_nxt_s = S_RUN;
        else            state_nxt_s = S_MEM_WAIT;
      end
      default: state_nxt_s = S_RUN;
    endcase
  end

  // Output logic, priority: reset, memory freeze, branch flush, load-use bubble.
  always_comb begin
    o_dmem_req    = 1'b0;
    o_pc_en       = 1'b1;
    o_IF_ID_en    = 1'b1;
    o_IF_ID_flush = 1'b0;
    o_ID_EX_en    = 1'b1;
    o_ID_EX_flush = 1'b0;
    o_EX_MEM_en   = 1'b1;
    o_MEM_WB_en   = 1'b1;
    if (i_reset) begin
      o_pc_en       = 1'b0;
      o_IF_ID_en    = 1'b0;
      o_IF_ID_flush = 1'b1;
      o_ID_EX_en    = 1'b0;
      o_ID_EX_flush = 1'b1;
      o_EX_MEM_en   = 1'b0;
      o_MEM_WB_en   = 1'b0;
    end else begin
      o_dmem_req = ((state_r == S_RUN) & i_MEM_mem_req) | (state_r == S_MEM_WAIT);
      if (wait_s) begin
        o_pc_en     = 1'b0;
        o_IF_ID_en  = 1'b0;
        o_ID_EX_en  = 1'b0;
        o_EX_MEM_en = 1'b0;
        o_MEM_WB_en = 1'b0;
      end else if (i_EX_br_taken) begin
        // The instruction in ID is wrong-path, so a pending load-use is moot.
        o_IF_ID_flush = 1'b1;
        o_ID_EX_flush = 1'b1;
      end else if (lu_s) begin
        o_pc_en       = 1'b0;
        o_IF_ID_en    = 1'b0;
        o_ID_EX_flush = 1'b1;
      end else begin
        o_IF_ID_flush = 1'b0;
      end
    end
  end

  // Wait-cycle counter and sticky timeout flag; timeout does not end the handshake.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt_r <= {TO_W{1'b0}};
      timeout_r  <= 1'b0;
    end else if (state_r == S_MEM_WAIT) begin
      if (wait_cnt_r < CNT_LIMIT) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end
      if (wait_cnt_r >= CNT_LAST) begin
        timeout_r <= 1'b1;
      end
    end else begin
      wait_cnt_r <= {TO_W{1'b0}};
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Event counters; natural 32-bit wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (wait_s | lu_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (i_EX_br_taken & ~wait_s) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
    end
  end

  assign o_stall_cycles = stall_cnt_r;
  assign o_flush_count  = flush_cnt_r;
`endif

endmodule
